// File: rtl/prio_arbiter.sv
// Registered N-way request arbiter (fixed-low, fixed-high or round-robin) with a held grant and valid/ready accept.
// Optional grant counter output gnt_count enabled by defining PRIO_ARB_GRANT_CNT_EN.
module prio_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int PRIO_MODE = 2,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic               gnt_valid,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    input  logic               gnt_ready
`ifdef PRIO_ARB_GRANT_CNT_EN
    ,
    output logic [31:0]        gnt_count
`endif
);

    generate
        if (NUM_REQ < 2) begin : g_bad_num_req
            $error("prio_arbiter: NUM_REQ must be at least 2");
        end
    endgenerate

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     ptr, ptr_nxt;
    logic [IDX_W-1:0]     win_idx, win_hi, win_lo;
    logic                 hi_found;
    logic                 accept;
    logic [IDX_W-1:0]     idx_nxt;
    logic [NUM_REQ-1:0]   onehot_nxt;

    // Successor with explicit wrap so a non-power-of-two pointer never reaches NUM_REQ.
    function automatic logic [IDX_W-1:0] succ(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    always_comb begin
        accept  = (state == GRANT) && gnt_ready;
        ptr_nxt = ptr;
        if (accept && (PRIO_MODE == 2)) begin
            ptr_nxt = succ(gnt_idx);
        end

        // Fixed-low is round-robin with the pointer pinned at 0; fixed-high scans the other way.
        win_idx  = '0;
        win_hi   = '0;
        win_lo   = '0;
        hi_found = 1'b0;
        if (PRIO_MODE == 1) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) win_idx = IDX_W'(i);
            end
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_lo = IDX_W'(i);
                    if (i >= int'(ptr_nxt)) begin
                        win_hi   = IDX_W'(i);
                        hi_found = 1'b1;
                    end
                end
            end
            win_idx = hi_found ? win_hi : win_lo;
        end

        state_nxt  = state;
        idx_nxt    = gnt_idx;
        onehot_nxt = gnt_onehot;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt  = GRANT;
                    idx_nxt    = win_idx;
                    onehot_nxt = NUM_REQ'(1) << win_idx;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    if (|req) begin
                        idx_nxt    = win_idx;
                        onehot_nxt = NUM_REQ'(1) << win_idx;
                    end else begin
                        state_nxt  = IDLE;
                        onehot_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            gnt_idx    <= idx_nxt;
            gnt_onehot <= onehot_nxt;
        end
    end

    assign gnt_valid = (state == GRANT);

`ifdef PRIO_ARB_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_count <= '0;
        end else if (accept) begin
            gnt_count <= gnt_count + 32'd1;
        end
    end
`endif

endmodule
